adbg_ahb3_burst_ctrl: RTL and testbench

Burst sequencer in the biu_clk (TCK) domain, directly upstream of the AHB3 bus-interface unit. It accepts one burst command (start address, word size, word count, direction) from the debug command decoder. It then issues that many single BIU accesses with auto-incrementing addresses, moving write data in and read data out over valid/ready streams. Bus errors are collected into a sticky flag and a first-error address for the decoder to report at end of burst.

---
 rtl/adbg_ahb3_pkg.sv | 32 +++
 rtl/adbg_ahb3_burst_ctrl_if.sv | 52 +++++
 rtl/adbg_ahb3_rd_hold.sv | 36 +++
 rtl/adbg_ahb3_burst_ctrl.sv | 157 +++++++++++++++
 tb/tb_adbg_ahb3_burst_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_ahb3_pkg.sv
`default_nettype none
// ============================================================================
// adbg_ahb3_pkg : burst FSM states and legal BIU word sizes.
// Revision 1.0
// ============================================================================
package adbg_ahb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } burst_state_e;

  localparam logic [3:0] WSIZE_1 = 4'd1;
  localparam logic [3:0] WSIZE_2 = 4'd2;
  localparam logic [3:0] WSIZE_4 = 4'd4;
  localparam logic [3:0] WSIZE_8 = 4'd8;

  // 8-byte words only exist on a 64-bit data path.
  function automatic logic size_legal(input logic [3:0] size, input logic wide);
    logic ok;
    case (size)
      WSIZE_1, WSIZE_2, WSIZE_4: ok = 1'b1;
      WSIZE_8:                   ok = wide;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adbg_ahb3_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// adbg_ahb3_burst_ctrl_if : command, data-stream and BIU signals of the burst
// sequencer. slave = the sequencer, master = decoder/BIU side. Revision 1.0
// ============================================================================
interface adbg_ahb3_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_size;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic                  cmd_rd;
  logic                  abort;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic                  err_clr;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic                  biu_strb;
  logic                  biu_rw;
  logic [3:0]            biu_word_size;
  logic [DATA_WIDTH-1:0] biu_di;
  logic [DATA_WIDTH-1:0] biu_do;
  logic                  biu_rdy;
  logic                  biu_err;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_size, cmd_count, cmd_rd, abort,
           wr_valid, wr_data, rd_ready, err_clr, biu_do, biu_rdy, biu_err,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, err_addr,
           biu_addr, biu_strb, biu_rw, biu_word_size, biu_di
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_count, cmd_rd, abort,
           wr_valid, wr_data, rd_ready, err_clr, biu_do, biu_rdy, biu_err,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, err_addr,
           biu_addr, biu_strb, biu_rw, biu_word_size, biu_di
  );
endinterface
`default_nettype wire

// File: rtl/adbg_ahb3_rd_hold.sv
`default_nettype none
// ============================================================================
// adbg_ahb3_rd_hold : one-entry valid/ready holding register for read data.
// Revision 1.0
// ============================================================================
module adbg_ahb3_rd_hold #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Data is left in place after a drain so the last word stays observable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/adbg_ahb3_burst_ctrl.sv
`default_nettype none
// ============================================================================
// adbg_ahb3_burst_ctrl : turns one burst command into a run of single BIU
// accesses with auto-incrementing address and sticky error capture. Rev 1.0
// ============================================================================
module adbg_ahb3_burst_ctrl
  import adbg_ahb3_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  adbg_ahb3_burst_ctrl_if.slave bus
);
  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            size_q, size_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  done_q, done_d;

  logic                  w_rd_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_abort;
  logic                  w_cmd_acc;
  logic                  w_cmd_bad;
  logic                  w_strb;
  logic                  w_complete;
  logic                  w_last;

  assign w_abort    = abort_q | bus.abort;
  assign w_cmd_acc  = (state_q == ST_IDLE) & bus.cmd_valid;
  assign w_cmd_bad  = w_cmd_acc & ~size_legal(bus.cmd_size, DATA_WIDTH == 64);
  assign w_complete = (state_q == ST_WAIT) & bus.biu_rdy;
  assign w_last     = (cnt_q == CNT_WIDTH'(1));

  // A pending abort suppresses any further strobe; reads need a free holding slot.
  assign w_strb = (state_q == ST_ISSUE) & ~w_abort & bus.biu_rdy &
                  (rd_q ? (~w_rd_valid | bus.rd_ready) : bus.wr_valid);

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (w_cmd_acc && !w_cmd_bad && bus.cmd_count != '0) state_d = ST_ISSUE;
      ST_ISSUE:
        if (w_strb)       state_d = ST_WAIT;
        else if (w_abort) state_d = w_rd_valid ? ST_HOLD : ST_IDLE;
      ST_WAIT:
        if (w_complete) begin
          if (w_last || w_abort) state_d = rd_q ? ST_HOLD : ST_IDLE;
          else                   state_d = ST_ISSUE;
        end
      ST_HOLD:
        if (!w_rd_valid || bus.rd_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.biu_strb  = w_strb;
    bus.wr_ready  = w_strb & ~rd_q;
    bus.biu_di    = (w_strb && !rd_q) ? bus.wr_data : '0;
  end

  always_comb begin
    addr_d     = addr_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    done_d     = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    abort_d    = (state_d != ST_IDLE) && (abort_q || ((state_q != ST_IDLE) && bus.abort));

    if (w_cmd_acc) begin
      addr_d = bus.cmd_addr;
      size_d = bus.cmd_size;
      cnt_d  = bus.cmd_count;
      rd_d   = bus.cmd_rd;
      if (w_cmd_bad || bus.cmd_count == '0) done_d = 1'b1;
    end

    if (w_complete) begin
      cnt_d  = cnt_q - CNT_WIDTH'(1);
      addr_d = addr_q + ADDR_WIDTH'(size_q);
    end

    // Clear first so an error arriving in the same cycle is still captured.
    if (bus.err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (w_cmd_bad) begin
      if (!err_d) err_addr_d = bus.cmd_addr;
      err_d = 1'b1;
    end
    if (w_complete && bus.biu_err) begin
      if (!err_d) err_addr_d = addr_q;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
    end
  end

  adbg_ahb3_rd_hold #(.DATA_WIDTH(DATA_WIDTH)) u_rd_hold (
    .clk_i       (biu_clk),
    .rst_i       (biu_rst),
    .load_i      (w_complete & rd_q),
    .load_data_i (bus.biu_do),
    .ready_i     (bus.rd_ready),
    .valid_o     (w_rd_valid),
    .data_o      (w_rd_data)
  );

  assign bus.rd_valid      = w_rd_valid;
  assign bus.rd_data       = w_rd_data;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.err_addr      = err_addr_q;
  assign bus.biu_addr      = addr_q;
  assign bus.biu_rw        = rd_q;
  assign bus.biu_word_size = size_q;
endmodule
`default_nettype wire

// File: tb/tb_adbg_ahb3_burst_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adbg_ahb3_burst_ctrl : directed bench with strobe/read-data scoreboards.
// Revision 1.0
// ============================================================================
module tb_adbg_ahb3_burst_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int BIU_LAT = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] di;
    logic [3:0]  sz;
  } strb_t;

  logic biu_clk = 1'b0;
  logic biu_rst;
  always #5 biu_clk = ~biu_clk;

  adbg_ahb3_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  adbg_ahb3_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .biu_clk (biu_clk),
    .biu_rst (biu_rst),
    .bus     (bus)
  );

  strb_t       sq[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  int n_cmp = 0;
  int n_mis = 0;
  int strb_cnt = 0, done_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic        err_en = 1'b0;
  logic        clr_hook = 1'b0;
  logic [31:0] ea1 = '0, ea2 = '0;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge biu_clk);
    #1;
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [3:0] s, input int c,
                            input logic rd, input logic [31:0] wbase);
    logic [31:0] x;
    for (int i = 0; i < c; i++) begin
      x = a + 32'(i) * 32'(s);
      sq.push_back('{addr: x, rw: rd, di: rd ? 32'h0 : wbase + 32'(i), sz: s});
      if (rd) rq.push_back(rdata(x));
      else    wq.push_back(wbase + 32'(i));
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [3:0] s, input logic [15:0] c,
                          input logic rd, input logic clr);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_count = c;
    bus.cmd_rd    = rd;
    bus.err_clr   = clr;
    @(negedge biu_clk);
    check("cmd_ready", bus.cmd_ready, 1);
    @(posedge biu_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge biu_clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int got = 0;
    for (int k = 0; k < 400 && got < n; k++) begin
      @(negedge biu_clk);
      if (bus.biu_strb) got++;
    end
    check({tag, "_strobes_seen"}, 64'(got), 64'(n));
  endtask

  // BIU model: checks each strobe against the scoreboard, answers after BIU_LAT cycles.
  initial begin
    strb_t       e;
    logic [31:0] a;
    bit          cut;
    bus.biu_rdy = 1'b1;
    bus.biu_do  = '0;
    bus.biu_err = 1'b0;
    forever begin
      @(negedge biu_clk);
      if (bus.biu_strb) begin
        a = bus.biu_addr;
        check("strobe_expected", 64'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          check("biu_addr", bus.biu_addr, e.addr);
          check("biu_rw", bus.biu_rw, e.rw);
          check("biu_word_size", bus.biu_word_size, e.sz);
          if (!e.rw) check("biu_di", bus.biu_di, e.di);
        end
        @(posedge biu_clk);
        #1 bus.biu_rdy = 1'b0;
        cut = 1'b0;
        for (int k = 0; k < BIU_LAT - 1; k++) begin
          @(posedge biu_clk);
          if (biu_rst) begin cut = 1'b1; break; end
        end
        #1;
        bus.biu_rdy = 1'b1;
        if (!cut) begin
          bus.biu_do  = rdata(a);
          bus.biu_err = err_en && (a == ea1 || a == ea2);
          if (clr_hook && bus.biu_err) bus.err_clr = 1'b1;
        end
        @(posedge biu_clk);
        #1;
        bus.biu_err = 1'b0;
        if (clr_hook) begin bus.err_clr = 1'b0; clr_hook = 1'b0; end
      end
    end
  end

  initial begin
    bit took;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(negedge biu_clk);
      took = bus.wr_ready && bus.wr_valid;
      @(posedge biu_clk);
      #1;
      if (took && wq.size() > 0) void'(wq.pop_front());
      bus.wr_valid = (wq.size() > 0);
      bus.wr_data  = (wq.size() > 0) ? wq[0] : '0;
    end
  end

  initial begin
    forever begin
      @(negedge biu_clk);
      if (bus.done)     done_cnt++;
      if (bus.biu_strb) strb_cnt++;
      if (bus.wr_ready) wr_cnt++;
      if (bus.rd_valid && bus.rd_ready) begin
        rd_cnt++;
        check("rd_expected", 64'(rq.size() > 0), 1);
        if (rq.size() > 0) check("rd_data", bus.rd_data, rq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, w0, r0;
    bit seen;
    biu_rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_count = '0;
    bus.cmd_rd = 1'b0; bus.abort = 1'b0; bus.rd_ready = 1'b1; bus.err_clr = 1'b0;
    step(3);
    biu_rst = 1'b0;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_addr", bus.err_addr, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_biu_strb", bus.biu_strb, 0);
    check("rst_biu_addr", bus.biu_addr, 0);
    step(2);

    // 1: write burst of three words
    push_burst(32'h100, 4'd4, 3, 1'b0, 32'hA);
    s0 = strb_cnt; d0 = done_cnt; w0 = wr_cnt;
    send_cmd(32'h100, 4'd4, 16'd3, 1'b0, 1'b0);
    wait_done("t1");
    check("t1_err", bus.err, 0);
    step(3);
    check("t1_strobes", 64'(strb_cnt - s0), 3);
    check("t1_wr_ready", 64'(wr_cnt - w0), 3);
    check("t1_done_pulses", 64'(done_cnt - d0), 1);
    check("t1_sq_empty", 64'(sq.size()), 0);

    // 2: read burst with back-pressure on the first word
    bus.rd_ready = 1'b0;
    push_burst(32'h201, 4'd1, 2, 1'b1, 32'h0);
    s0 = strb_cnt; d0 = done_cnt; r0 = rd_cnt;
    send_cmd(32'h201, 4'd1, 16'd2, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge biu_clk);
      if (bus.rd_valid) begin seen = 1'b1; break; end
    end
    check("t2_first_rd_valid", 64'(seen), 1);
    step(10);
    check("t2_second_strobe_withheld", 64'(strb_cnt - s0), 1);
    check("t2_no_early_done", 64'(done_cnt - d0), 0);
    check("t2_rd_data_held", bus.rd_data, rdata(32'h201));
    bus.rd_ready = 1'b1;
    wait_done("t2");
    check("t2_rd_valid_at_done", bus.rd_valid, 0);
    step(1);
    check("t2_strobes", 64'(strb_cnt - s0), 2);
    check("t2_rd_words", 64'(rd_cnt - r0), 2);

    // 3: read burst with errors on accesses 2 and 3
    err_en = 1'b1; ea1 = 32'h402; ea2 = 32'h404;
    push_burst(32'h400, 4'd2, 4, 1'b1, 32'h0);
    s0 = strb_cnt; r0 = rd_cnt;
    send_cmd(32'h400, 4'd2, 16'd4, 1'b1, 1'b0);
    wait_done("t3");
    step(1);
    err_en = 1'b0;
    check("t3_strobes", 64'(strb_cnt - s0), 4);
    check("t3_rd_words", 64'(rd_cnt - r0), 4);
    check("t3_err", bus.err, 1);
    check("t3_err_addr", bus.err_addr, 32'h402);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("t3_err_cleared", bus.err, 0);
    check("t3_err_addr_cleared", bus.err_addr, 0);

    // 4: write burst of five aborted during the second access
    push_burst(32'h500, 4'd4, 2, 1'b0, 32'h50);
    wq.push_back(32'h52); wq.push_back(32'h53); wq.push_back(32'h54);
    s0 = strb_cnt; d0 = done_cnt; w0 = wr_cnt;
    send_cmd(32'h500, 4'd4, 16'd5, 1'b0, 1'b0);
    wait_strobes(2, "t4");
    step(1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    wait_done("t4");
    step(3);
    check("t4_strobes", 64'(strb_cnt - s0), 2);
    check("t4_wr_ready", 64'(wr_cnt - w0), 2);
    check("t4_done_pulses", 64'(done_cnt - d0), 1);
    check("t4_busy", bus.busy, 0);
    wq.delete();

    // 5: zero count, illegal size, address wrap
    s0 = strb_cnt; d0 = done_cnt;
    send_cmd(32'h300, 4'd4, 16'd0, 1'b0, 1'b0);
    @(negedge biu_clk);
    check("t5_cnt0_done", bus.done, 1);
    check("t5_cnt0_busy", bus.busy, 0);
    step(3);
    check("t5_cnt0_strobes", 64'(strb_cnt - s0), 0);
    check("t5_cnt0_done_pulses", 64'(done_cnt - d0), 1);
    send_cmd(32'h7777_0000, 4'd8, 16'd3, 1'b0, 1'b0);
    @(negedge biu_clk);
    check("t5_size8_done", bus.done, 1);
    check("t5_size8_err", bus.err, 1);
    check("t5_size8_err_addr", bus.err_addr, 32'h7777_0000);
    step(3);
    check("t5_size8_strobes", 64'(strb_cnt - s0), 0);
    push_burst(32'hFFFF_FFFC, 4'd4, 2, 1'b0, 32'hC0);
    s0 = strb_cnt;
    send_cmd(32'hFFFF_FFFC, 4'd4, 16'd2, 1'b0, 1'b0);
    wait_done("t5_wrap");
    step(1);
    check("t5_wrap_strobes", 64'(strb_cnt - s0), 2);
    check("t5_wrap_sq_empty", 64'(sq.size()), 0);

    // 6: err_clr coincident with a command error, then with a bus error
    send_cmd(32'h1234_5678, 4'd3, 16'd1, 1'b0, 1'b1);
    @(negedge biu_clk);
    check("t6_cmd_err", bus.err, 1);
    check("t6_cmd_err_addr", bus.err_addr, 32'h1234_5678);
    step(1);
    err_en = 1'b1; ea1 = 32'h600; ea2 = 32'h600; clr_hook = 1'b1;
    push_burst(32'h600, 4'd4, 1, 1'b1, 32'h0);
    send_cmd(32'h600, 4'd4, 16'd1, 1'b1, 1'b0);
    wait_done("t6_bus");
    step(1);
    err_en = 1'b0;
    check("t6_bus_err", bus.err, 1);
    check("t6_bus_err_addr", bus.err_addr, 32'h600);

    // 7: reset while waiting on the BIU, then a fresh command
    push_burst(32'h700, 4'd4, 1, 1'b0, 32'h70);
    wq.push_back(32'h71); wq.push_back(32'h72);
    send_cmd(32'h700, 4'd4, 16'd3, 1'b0, 1'b0);
    wait_strobes(1, "t7");
    step(2);
    biu_rst = 1'b1;
    #1;
    check("t7_rst_cmd_ready", bus.cmd_ready, 1);
    check("t7_rst_busy", bus.busy, 0);
    check("t7_rst_strb", bus.biu_strb, 0);
    check("t7_rst_wr_ready", bus.wr_ready, 0);
    check("t7_rst_err", bus.err, 0);
    check("t7_rst_err_addr", bus.err_addr, 0);
    check("t7_rst_biu_addr", bus.biu_addr, 0);
    check("t7_rst_done", bus.done, 0);
    step(1);
    biu_rst = 1'b0;
    sq.delete();
    wq.delete();
    step(3);
    push_burst(32'h40, 4'd4, 1, 1'b0, 32'h99);
    s0 = strb_cnt;
    send_cmd(32'h40, 4'd4, 16'd1, 1'b0, 1'b0);
    wait_done("t7_after");
    step(1);
    check("t7_after_strobes", 64'(strb_cnt - s0), 1);
    check("t7_after_sq_empty", 64'(sq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
